// File: rtl/pixel_sink.sv
// Receiving end of the drawers' pixel stream: clips off-screen pixels, buffers the rest in a
// small FIFO and drains them to the framebuffer port, with a full-screen clear sequence.
module pixel_sink #(
  parameter int           SCREEN_W   = 160,
  parameter int           SCREEN_H   = 120,
  parameter int           FIFO_DEPTH = 8,
  parameter int           ADDR_W     = 15,
  parameter logic [2:0]   CLEAR_COL  = 3'd0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [2:0]        colour,
  input  logic              writeEn,
  input  logic              clear_req,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [7:0]        clip_cnt,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        col;
  } entry_t;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;

  logic        in_range, push, pop, drop, clip;
  logic [31:0] lin_addr;
  entry_t      head;

  // Linear address computed at 32 bits, then truncated to the port width.
  assign lin_addr = 32'(y) * 32'(SCREEN_W) + 32'(x);
  assign in_range = (32'(x) < 32'(SCREEN_W)) && (32'(y) < 32'(SCREEN_H));

  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = fifo_mem[rd_ptr];
  assign busy  = (state == S_CLEAR);

  // A clear request in IDLE wins over draining the head this cycle.
  assign pop  = (state == S_IDLE) && !empty && mem_ready && !clear_req;
  assign push = writeEn && in_range && (!full || pop);
  assign drop = writeEn && in_range && full && !pop;
  assign clip = writeEn && !in_range;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          mem_we   = 1'b1;
          mem_addr = head.addr;
          mem_data = head.col;
        end
      end
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_addr;
        mem_data = CLEAR_COL;
      end
      default: ;
    endcase
  end

  // NOTE: the FIFO storage has no reset; the pointers and count alone define what is valid,
  // and leaving the array unreset lets it map onto plain RAM/registers without reset muxes.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: lin_addr[ADDR_W-1:0], col: colour};
  end

  // NOTE: all state updates use non-blocking assignments so every register samples the
  // pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= S_IDLE;
      clr_addr <= '0;
      overflow <= 1'b0;
      clip_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (drop) overflow <= 1'b1;
      if (clip && clip_cnt != 8'hFF) clip_cnt <= clip_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (clear_req) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
          end
        end
        S_CLEAR: begin
          if (mem_ready) begin
            if (clr_addr == LAST_ADDR) begin
              state    <= S_IDLE;
              clr_addr <= '0;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sink.sv
// Directed bench for pixel_sink: a queue of expected writes is filled as pixels are driven
// and drained by a monitor that checks every memory transfer.
module tb_pixel_sink;

  localparam int W = 160;
  localparam int H = 120;
  localparam int SCREEN = W * H;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic [2:0]  colour = '0;
  logic        writeEn = 1'b0, clear_req = 1'b0, mem_ready = 1'b0;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we, full, empty, overflow, busy;
  logic [7:0]  clip_cnt;

  typedef struct {
    int addr;
    int col;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   clr_exp = 0;
  int   clear_writes = 0;

  pixel_sink dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .clear_req(clear_req), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .full(full), .empty(empty), .overflow(overflow), .clip_cnt(clip_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int px, input int py, input int c, input bit accept);
    x = 10'(px);
    y = 10'(py);
    colour = 3'(c);
    writeEn = 1'b1;
    if (accept) sb.push_back('{addr: py * W + px, col: c});
    step();
    writeEn = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    writeEn = 1'b0;
    clear_req = 1'b0;
    mem_ready = 1'b0;
    sb.delete();
    step();
    resetn = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    mem_ready = 1'b1;
    while ((busy || !empty) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: a transfer happens at the next posedge whenever mem_we and mem_ready are high now.
  always @(negedge clk) begin
    if (resetn && mem_we && mem_ready) begin
      if (busy) begin
        check("clear_addr", 32'(mem_addr), 32'(clr_exp));
        check("clear_data", 32'(mem_data), 32'd0);
        clr_exp++;
        clear_writes++;
      end else if (clear_req) begin
        clr_exp = 0;
        clear_writes = 0;
      end else begin
        check("write_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("pix_addr", 32'(mem_addr), 32'(e.addr));
          check("pix_data", 32'(mem_data), 32'(e.col));
        end
      end
    end
  end

  initial begin
    step();
    step();
    do_reset();

    // Reset state
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_data", 32'(mem_data), 0);
    check("rst_full", 32'(full), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_clip", 32'(clip_cnt), 0);

    // Single pixel, one-cycle latency
    mem_ready = 1'b1;
    send(5, 2, 4, 1'b1);
    check("t1_we", 32'(mem_we), 1);
    check("t1_addr", 32'(mem_addr), 325);
    check("t1_data", 32'(mem_data), 4);
    step();
    check("t1_empty", 32'(empty), 1);
    check("t1_we_off", 32'(mem_we), 0);
    check("t1_addr_off", 32'(mem_addr), 0);

    // Fill with no drain, overflow on the 9th
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send(i * 3 + 1, i + 10, i % 8, i < 8);
      if (i == 6) check("t2_not_full_7", 32'(full), 0);
      if (i == 7) begin
        check("t2_full_8", 32'(full), 1);
        check("t2_ovf_8", 32'(overflow), 0);
      end
    end
    check("t2_ovf_9", 32'(overflow), 1);
    check("t2_hold_addr", 32'(mem_addr), 10 * W + 1);
    drain("t2", 50);
    check("t2_ovf_sticky", 32'(overflow), 1);

    // Push while full with a simultaneous pop
    do_reset();
    for (int i = 0; i < 8; i++) send(i + 20, 50, 7 - i, 1'b1);
    check("t5_full", 32'(full), 1);
    mem_ready = 1'b1;
    send(100, 60, 3, 1'b1);
    mem_ready = 1'b0;
    check("t5_full_kept", 32'(full), 1);
    check("t5_ovf", 32'(overflow), 0);
    drain("t5", 50);

    // Clipping and saturation
    send(160, 0, 1, 1'b0);
    check("t3_clip1", 32'(clip_cnt), 1);
    check("t3_no_we", 32'(mem_we), 0);
    send(0, 120, 1, 1'b0);
    check("t3_clip2", 32'(clip_cnt), 2);
    mem_ready = 1'b1;
    send(159, 119, 6, 1'b1);
    check("t3_corner_addr", 32'(mem_addr), 19199);
    check("t3_corner_we", 32'(mem_we), 1);
    step();
    writeEn = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x = (i % 2 == 1) ? 10'd200 : 10'd5;
      y = (i % 2 == 1) ? 10'd5 : 10'd1023;
      step();
    end
    writeEn = 1'b0;
    check("t3_clip_sat", 32'(clip_cnt), 255);
    check("t3_empty", 32'(empty), 1);

    // Full-screen clear with pixels arriving during it
    mem_ready = 1'b1;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("t4_busy", 32'(busy), 1);
    send(1, 1, 2, 1'b1);
    send(2, 1, 3, 1'b1);
    send(3, 1, 5, 1'b1);
    step();
    check("t4_no_drain", 32'(empty), 0);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    drain("t4", SCREEN + 100);
    check("t4_clear_writes", 32'(clear_writes), SCREEN);
    check("t4_busy_done", 32'(busy), 0);

    // Clear priority over pop, then reset mid-clear with 3 pixels buffered
    mem_ready = 1'b0;
    send(10, 10, 1, 1'b1);
    mem_ready = 1'b1;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("t6_busy", 32'(busy), 1);
    check("t6_no_pop", 32'(empty), 0);
    send(11, 10, 2, 1'b1);
    send(12, 10, 3, 1'b1);
    repeat (100) step();
    check("t6_busy_mid", 32'(busy), 1);
    check("t6_pending", 32'(sb.size()), 3);
    do_reset();
    check("t6_we", 32'(mem_we), 0);
    check("t6_busy_rst", 32'(busy), 0);
    check("t6_empty", 32'(empty), 1);
    mem_ready = 1'b1;
    repeat (50) step();
    check("t6_still_empty", 32'(empty), 1);
    check("t6_still_idle", 32'(mem_we), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
